fc_mem_loader: RTL

- Write-side streaming loader for the FC weight/bias memory: accepts 16-bit words over a valid/ready stream and turns them into single-word writes at consecutive addresses.
- Sits between the IO input stream and the FC memory write port (address / data_in / write_enable).
- One start command loads one contiguous region, for example the 120*84 layer-2 weight block.
- Keeps the memory read strobe deasserted while loading, so the memory's wide read side only sees stable regions.

---
 rtl/fc_mem_loader_if.sv | 25 ++
 rtl/fc_mem_loader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fc_mem_loader_if.sv
// Stream-in and memory-write-port bundle for the FC weight/bias memory loader.
// master = stream source / memory side, slave = the loader itself.
`timescale 1ns/1ps
interface fc_mem_loader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_enable;
    logic              mem_read_enable;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_address, mem_data_in, mem_write_enable, mem_read_enable
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_address, mem_data_in, mem_write_enable, mem_read_enable
    );
endinterface

// File: rtl/fc_mem_loader.sv
// Streaming loader: one start command writes len stream words to consecutive FC memory addresses.
// Optional `FC_LOAD_CHECKSUM_EN adds a load_sum output (mod 2^DATA_W sum of accepted words).
`timescale 1ns/1ps
module fc_mem_loader #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [LEN_W-1:0]  load_len,
    fc_mem_loader_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  word_count
`ifdef FC_LOAD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] load_sum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              accept;
`ifdef FC_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    // Every output is a register; next values are computed here and captured below.
    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        count_d    = count_q;
        base_d     = base_q;
        len_d      = len_q;
`ifdef FC_LOAD_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        accept     = bus.in_valid & in_ready_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = load_base;
                    len_d   = load_len;
                    count_d = '0;
`ifdef FC_LOAD_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    if (load_len != '0) begin
                        state_d    = LOAD;
                        in_ready_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    addr_d  = base_q + ADDR_W'(count_q);
                    data_d  = bus.in_data;
                    we_d    = 1'b1;
                    count_d = count_q + 1'b1;
`ifdef FC_LOAD_CHECKSUM_EN
                    sum_d   = sum_q + bus.in_data;
`endif
                    // Drop ready on the final accept so no word beyond len is taken.
                    if (count_d == len_q) begin
                        state_d    = FLUSH;
                        in_ready_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
            end
        endcase

        busy_d  = (state_d != IDLE);
        rd_en_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            count_q    <= '0;
            base_q     <= '0;
            len_q      <= '0;
`ifdef FC_LOAD_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            count_q    <= count_d;
            base_q     <= base_d;
            len_q      <= len_d;
`ifdef FC_LOAD_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_data_in      = data_q;
    assign bus.mem_write_enable = we_q;
    assign bus.mem_read_enable  = rd_en_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign word_count           = count_q;
`ifdef FC_LOAD_CHECKSUM_EN
    assign load_sum             = sum_q;
`endif

endmodule
